// File: rtl/hazard_pkg.sv
// Shared constants for the decode-stage hazard scoreboard: producer latencies
// and stall_why bit positions.
package hazard_pkg;

  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;
  localparam int LAT_MF   = 1;
  localparam int LAT_LINK = 1;

  localparam int SW_SRC1 = 0;
  localparam int SW_SRC2 = 1;
  localparam int SW_WAW  = 2;
  localparam int SW_MDU  = 3;

  typedef logic [3:0] stall_why_t;

endpackage

// File: rtl/hazard_scoreboard_mdu_timer.sv
// MDU busy timer: loads the operation latency on issue and counts down to idle.
// Instantiated only when SB_MDU_TRACK_EN is defined.
module mdu_busy_timer
  import hazard_pkg::*;
#(
  parameter int MCW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [MCW-1:0] load_val,
  output logic           busy
);

  logic [MCW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - MCW'(1);
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard stall unit beside decode: per-register countdown to forwardable,
// plus MDU busy tracking (internal timer when SB_MDU_TRACK_EN is defined).
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int LW      = 3,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int MCW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic          src1_en,
  input  logic          src2_en,
  input  logic [AW-1:0] src1,
  input  logic [AW-1:0] src2,
  input  logic          src_early,
  input  logic          dst_en,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] dst_lat,
  input  logic          mdu_op,
  input  logic          mdu_div,
  input  logic          hilo_acc,
  input  logic          mdu_busy,
  input  logic          flush,
  output logic          stall,
  output logic [3:0]    stall_why
);

  logic [LW-1:0] cnt [NREG];
  logic          issue_go;
  logic          mdu_busy_q;
  stall_why_t    hz;

  always_comb begin
    hz = '0;
    hz[SW_SRC1] = src1_en && (src1 != '0) &&
                  (src_early ? (cnt[src1] != '0) : (cnt[src1] > LW'(1)));
    hz[SW_SRC2] = src2_en && (src2 != '0) &&
                  (src_early ? (cnt[src2] != '0) : (cnt[src2] > LW'(1)));
    hz[SW_WAW]  = dst_en && (dst != '0) && (cnt[dst] > dst_lat);
    hz[SW_MDU]  = (mdu_op || hilo_acc) && mdu_busy_q;
  end

  assign stall     = issue_valid && !flush && (|hz);
  assign stall_why = stall ? hz : 4'b0000;
  assign issue_go  = issue_valid && !stall && !flush;

  // Entry 0 is held at zero so r0 never reports a hazard.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset || flush || i == 0)
        cnt[i] <= '0;
      else if (issue_go && dst_en && dst == AW'(i))
        cnt[i] <= dst_lat;
      else if (cnt[i] != '0)
        cnt[i] <= cnt[i] - LW'(1);
    end
  end

`ifdef SB_MDU_TRACK_EN
  // Flush does not reach the timer: an MDU operation cannot be cancelled.
  mdu_busy_timer #(.MCW(MCW)) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (issue_go && mdu_op),
    .load_val (mdu_div ? MCW'(DIV_LAT) : MCW'(MUL_LAT)),
    .busy     (mdu_busy_q)
  );

  logic unused_mdu_busy;
  assign unused_mdu_busy = mdu_busy;
`else
  assign mdu_busy_q = mdu_busy;

  logic unused_cfg;
  assign unused_cfg = ^{mdu_div, MUL_LAT, DIV_LAT, MCW};
`endif

endmodule
